// File: rtl/syscnt_pwm.sv
// syscnt_pwm
//   Follows the free-running counter from vlg_design. It flags every wrap
//   from all-ones back to zero and counts completed periods. It also checks
//   that the counter only holds or steps by +1, and drives a PWM output. The
//   PWM duty is loaded through a valid/ready handshake and only changes on a
//   period boundary.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   syscnt      counter value being tracked (CNT_W bits)
//   duty_in     requested high-count per period, 0..2^CNT_W (saturates above)
//   duty_valid  duty_in is valid
//   duty_ready  block can accept a duty value
//   pwm_out     registered PWM output
//   wrap_pulse  one-cycle pulse after each wrap to zero
//   period_cnt  completed wraps, modulo 2^PCNT_W
//   seq_err     sticky illegal-step flag
//   err_clr     clears seq_err (a new error in the same cycle wins)
module syscnt_pwm #(
  parameter int CNT_W  = 4,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  syscnt,
  input  logic [CNT_W:0]    duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              pwm_out,
  output logic              wrap_pulse,
  output logic [PCNT_W-1:0] period_cnt,
  output logic              seq_err,
  input  logic              err_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   DUTY_MAX = {1'b1, {CNT_W{1'b0}}};

  logic [CNT_W-1:0] syscnt_d;
  logic             primed;
  logic [CNT_W:0]   duty_act;
  logic [CNT_W:0]   duty_pend;
  logic             pending;

  logic             wrap;
  logic             step_ok;
  logic             transfer;
  logic [CNT_W:0]   duty_sat;
  logic [CNT_W:0]   duty_eff;
  logic [CNT_W-1:0] syscnt_inc;

  // The checks compare against the previous sample. They stay disabled until
  // one sample has been taken after reset, so that release never looks like a wrap.
  always_comb begin
    syscnt_inc = syscnt_d + 1'b1;
    wrap       = primed && (syscnt_d == CNT_MAX) && (syscnt == '0);
    step_ok    = (syscnt == syscnt_d) || (syscnt == syscnt_inc);
    duty_ready = rst_n & ~pending;
    transfer   = duty_valid & duty_ready;
    duty_sat   = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
    // A pending duty is applied on the wrap sample itself, so the new value
    // already governs the zero sample of its first period.
    duty_eff   = (wrap && pending) ? duty_pend : duty_act;
  end

  // Counter tracking, wrap pulse and period count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      syscnt_d   <= '0;
      primed     <= 1'b0;
      wrap_pulse <= 1'b0;
      period_cnt <= '0;
    end else begin
      syscnt_d   <= syscnt;
      primed     <= 1'b1;
      wrap_pulse <= wrap;
      if (wrap)
        period_cnt <= period_cnt + 1'b1;
    end
  end

  // Sticky sequence error. Setting takes priority over clearing.
  always_ff @(posedge clk) begin
    if (!rst_n)
      seq_err <= 1'b0;
    else if (primed && !step_ok)
      seq_err <= 1'b1;
    else if (err_clr)
      seq_err <= 1'b0;
  end

  // One-entry duty holding register. A transfer can only happen while
  // pending is clear, so it never collides with an apply on the same wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_pend <= '0;
      duty_act  <= '0;
      pending   <= 1'b0;
    end else if (transfer) begin
      duty_pend <= duty_sat;
      pending   <= 1'b1;
    end else if (wrap && pending) begin
      duty_act  <= duty_pend;
      pending   <= 1'b0;
    end
  end

  // PWM compare. The counter is zero-extended so that the full-scale duty
  // gives a constant high output.
  always_ff @(posedge clk) begin
    if (!rst_n)
      pwm_out <= 1'b0;
    else
      pwm_out <= primed && ({1'b0, syscnt} < duty_eff);
  end

endmodule
